// File: rtl/dct_pkg.sv
// Shared constants and types for the quantize / zig-zag stage.
package dct_pkg;

  localparam int unsigned COEF_W = 10;
  localparam int unsigned NCOEF  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SH_W   = 2;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic        [IDX_W-1:0]  idx_t;
  typedef logic        [SH_W-1:0]   shift_t;

  typedef enum logic {IDLE, SEND} rd_state_e;

  // One registered output beat towards the entropy coder.
  typedef struct packed {
    logic  valid;
    logic  last;
    coef_t data;
  } out_beat_t;

  // Shift per raster position, stored as (s-1) so the range 1..4 fits two bits.
  localparam shift_t QSHIFT [NCOEF] = '{
    2'd0, 2'd0, 2'd1, 2'd1,
    2'd0, 2'd1, 2'd1, 2'd2,
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd3
  };

  // Raster index emitted in each output slot.
  localparam idx_t ZIGZAG [NCOEF] = '{
    4'd0,  4'd1,  4'd4,  4'd8,
    4'd5,  4'd2,  4'd3,  4'd6,
    4'd9,  4'd12, 4'd13, 4'd10,
    4'd7,  4'd11, 4'd14, 4'd15
  };

endpackage

// File: rtl/quant_zigzag_if.sv
// Coefficient stream in from the DCT stage and zig-zag stream out to the entropy coder.
interface quant_zigzag_if;
  import dct_pkg::*;

  logic  in_valid;
  coef_t in_data;
  logic  out_valid;
  coef_t out_data;
  logic  out_last;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/quant_round.sv
// Combinational quantizer: sign(c) * ((|c| + 2^(s-1)) >> s), round half away from zero.
module quant_round
  import dct_pkg::*;
(
  input  coef_t  i_coef,
  input  shift_t i_shift_m1,
  output coef_t  o_q
);

  localparam int unsigned MAG_W = COEF_W + 1;

  logic signed [MAG_W-1:0] w_ext;
  logic        [MAG_W-1:0] w_abs;
  logic        [MAG_W-1:0] w_half;
  logic        [MAG_W-1:0] w_mag;
  logic        [2:0]       w_shift;
  logic                    w_neg;

  // One extra bit keeps |-512| representable.
  assign w_ext   = {i_coef[COEF_W-1], i_coef};
  assign w_neg   = w_ext[MAG_W-1];
  assign w_abs   = w_neg ? MAG_W'(-w_ext) : MAG_W'(w_ext);
  assign w_half  = MAG_W'(1) << i_shift_m1;
  assign w_shift = 3'(i_shift_m1) + 3'd1;
  assign w_mag   = (w_abs + w_half) >> w_shift;
  assign o_q     = w_neg ? COEF_W'(-w_mag) : COEF_W'(w_mag);

endmodule

// File: rtl/quant_zigzag.sv
// Quantizes 4x4 coefficient blocks into a ping-pong buffer and streams them out in zig-zag order.
module quant_zigzag
  import dct_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  quant_zigzag_if.slave  bus
);

  coef_t     r_bank [2][NCOEF];
  logic [1:0] r_full;
  logic [1:0] w_full_nxt;
  logic      r_wr_bank;
  logic      r_rd_bank;
  logic      w_rd_bank_nxt;
  idx_t      r_wr_cnt;
  idx_t      r_rd_cnt;
  idx_t      w_rd_cnt_nxt;
  rd_state_e r_state;
  rd_state_e w_state_nxt;
  out_beat_t r_out;
  out_beat_t w_out_nxt;
  coef_t     w_q;
  logic      w_wr_done;
  logic      w_emit;

  quant_round u_quant (
    .i_coef     (bus.in_data),
    .i_shift_m1 (QSHIFT[r_wr_cnt]),
    .o_q        (w_q)
  );

  assign w_wr_done = bus.in_valid && (r_wr_cnt == idx_t'(NCOEF - 1));

  // Bank contents need no reset: r_full alone says whether a bank holds a block.
  always_ff @(posedge clk) begin
    if (bus.in_valid) r_bank[r_wr_bank][r_wr_cnt] <= w_q;
  end

  // Write side: a gap in in_valid restarts the block at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (bus.in_valid) begin
      r_wr_cnt <= r_wr_cnt + idx_t'(1);
      if (w_wr_done) r_wr_bank <= ~r_wr_bank;
    end else begin
      r_wr_cnt <= '0;
    end
  end

  // Read FSM: the IDLE cycle that sees a full bank already emits slot 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_rd_bank_nxt = r_rd_bank;
    w_full_nxt    = r_full;
    w_out_nxt     = '0;
    w_emit        = 1'b0;

    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;

    case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = SEND;
          w_emit      = 1'b1;
        end
      end
      SEND:    w_emit      = 1'b1;
      default: w_state_nxt = IDLE;
    endcase

    if (w_emit) begin
      w_out_nxt.valid = 1'b1;
      w_out_nxt.data  = r_bank[r_rd_bank][ZIGZAG[r_rd_cnt]];
      w_rd_cnt_nxt    = r_rd_cnt + idx_t'(1);
      if (r_rd_cnt == idx_t'(NCOEF - 1)) begin
        w_out_nxt.last        = 1'b1;
        w_full_nxt[r_rd_bank] = 1'b0;
        w_rd_bank_nxt         = ~r_rd_bank;
        w_state_nxt           = r_full[~r_rd_bank] ? SEND : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
      r_out     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_full    <= w_full_nxt;
      r_out     <= w_out_nxt;
    end
  end

  assign bus.out_valid = r_out.valid;
  assign bus.out_data  = r_out.data;
  assign bus.out_last  = r_out.last;

endmodule
